pulse_stretcher: RTL and testbench

//   Converts single-cycle event pulses, e.g. from an edge detector, back into a

---
 rtl/pulse_stretcher_if.sv | 41 ++++
 rtl/pulse_stretcher.sv | 150 +++++++++++++++
 tb/tb_pulse_stretcher.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_if.sv
// ---------------------------------------------------------------------------
// pulse_stretcher_if
//   Groups the trigger/length inputs and the stretched-pulse status outputs
//   of pulse_stretcher into one bundle.
//
//   Signals:
//     in       trigger level, 1 = event, sampled each rising edge
//     len      pulse length in cycles (N bits), used only on an accepted trigger
//     out      stretched pulse
//     busy     high while the stretcher is in HIGH or HOLD
//     dropped  one-cycle flag: a sampled trigger was not accepted
//
//   Modports:
//     master   the event source (drives in/len, observes status)
//     slave    the stretcher itself
// ---------------------------------------------------------------------------
interface pulse_stretcher_if #(
    parameter int N = 8
);
    logic         in;
    logic [N-1:0] len;
    logic         out;
    logic         busy;
    logic         dropped;

    modport master (
        output in,
        output len,
        input  out,
        input  busy,
        input  dropped
    );

    modport slave (
        input  in,
        input  len,
        output out,
        output busy,
        output dropped
    );
endinterface

// File: rtl/pulse_stretcher.sv
// ---------------------------------------------------------------------------
// pulse_stretcher
//   Turns single-cycle event strobes into a clean high window of programmable
//   length, with optional retrigger and a post-pulse holdoff during which new
//   triggers are ignored.
//
//   Parameters:
//     N          width of len and of the pulse down-counter
//     RETRIGGER  1: a trigger during a pulse reloads the counter
//                0: a trigger during a pulse is ignored and flagged as dropped
//     HOLDOFF    number of low cycles forced after each pulse (0 = none)
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous reset, active-low
//     bus.in     trigger (level, sampled each edge)
//     bus.len    pulse length, captured only when a trigger is accepted
//     bus.out    stretched pulse, registered
//     bus.busy   registered, 1 while state is HIGH or HOLD
//     bus.dropped registered one-cycle flag for a trigger that was not accepted
// ---------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int N         = 8,
    parameter int RETRIGGER = 1,
    parameter int HOLDOFF   = 2
) (
    input  logic              clk,
    input  logic              rst,
    pulse_stretcher_if.slave  bus
);

    // Hold counter only needs to represent 0..HOLDOFF.
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state,    state_d;
    logic [N-1:0]   cnt,      cnt_d;
    logic [HW-1:0]  hold_cnt, hold_d;
    logic           out_q,    out_d;
    logic           busy_q,   busy_d;
    logic           drop_q,   drop_d;
    logic           trig_ok;

    // A trigger with len==0 never starts or reloads a pulse.
    assign trig_ok = bus.in && (bus.len != '0);

    // -----------------------------------------------------------------------
    // State / counter / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hold_cnt <= '0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            hold_cnt <= hold_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hold_d  = hold_cnt;
        drop_d  = 1'b0;

        case (state)
            IDLE: begin
                if (trig_ok) begin
                    state_d = HIGH;
                    cnt_d   = bus.len;
                end else if (bus.in) begin
                    drop_d  = 1'b1;
                end
            end

            HIGH: begin
                if (RETRIGGER != 0 && trig_ok) begin
                    // Reload wins even on the edge where the pulse would end.
                    cnt_d = bus.len;
                end else begin
                    if (bus.in) begin
                        drop_d = 1'b1;
                    end
                    // cnt<=1 (not ==1) so the counter can never wrap in HIGH.
                    if (cnt <= N'(1)) begin
                        cnt_d = '0;
                        if (HOLDOFF > 0) begin
                            state_d = HOLD;
                            hold_d  = HW'(HOLDOFF);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt - N'(1);
                    end
                end
            end

            HOLD: begin
                if (hold_cnt <= HW'(1)) begin
                    // Last holdoff cycle: this edge already behaves like IDLE.
                    hold_d  = '0;
                    state_d = IDLE;
                    if (trig_ok) begin
                        state_d = HIGH;
                        cnt_d   = bus.len;
                    end else if (bus.in) begin
                        drop_d  = 1'b1;
                    end
                end else begin
                    hold_d = hold_cnt - HW'(1);
                    if (bus.in) begin
                        drop_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        // out and busy are registered images of the next state.
        out_d  = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.dropped = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretcher
//   Directed bench for pulse_stretcher. Two instances share clock and reset:
//     dut_rt  RETRIGGER=1, HOLDOFF=2
//     dut_nr  RETRIGGER=0, HOLDOFF=2
//   Inputs change 1 time unit after a rising edge; outputs are sampled
//   1 time unit after the edge that produced them. "Edge k" is the k-th
//   rising edge of a scenario, the first one that sees the stimulus.
// ---------------------------------------------------------------------------
module tb_pulse_stretcher;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    pulse_stretcher_if #(.N(N)) if_rt ();
    pulse_stretcher_if #(.N(N)) if_nr ();

    pulse_stretcher #(.N(N), .RETRIGGER(1), .HOLDOFF(2)) dut_rt (
        .clk (clk),
        .rst (rst),
        .bus (if_rt.slave)
    );

    pulse_stretcher #(.N(N), .RETRIGGER(0), .HOLDOFF(2)) dut_nr (
        .clk (clk),
        .rst (rst),
        .bus (if_nr.slave)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle 1 unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_both(input int cycles);
        if_rt.in = 1'b0;
        if_nr.in = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic test_reset();
        // Outputs while reset is held from time 0.
        #1;
        n_cmp++;
        if ({if_rt.out, if_rt.busy, if_rt.dropped} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_init_rt: got out/busy/dropped=%b want 000",
                     {if_rt.out, if_rt.busy, if_rt.dropped});
        end
        n_cmp++;
        if ({if_nr.out, if_nr.busy, if_nr.dropped} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_init_nr: got out/busy/dropped=%b want 000",
                     {if_nr.out, if_nr.busy, if_nr.dropped});
        end
        @(negedge clk);
        rst = 1'b1;
        step();

        // Start a len=5 pulse, then reset asynchronously during cycle 2.
        if_rt.len = 8'd5;
        if_rt.in  = 1'b1;
        step();
        if_rt.in  = 1'b0;
        step();
        n_cmp++;
        if (if_rt.out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_pulse: got out=%b want 1", if_rt.out);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({if_rt.out, if_rt.busy, if_rt.dropped} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async_abort: got out/busy/dropped=%b want 000",
                     {if_rt.out, if_rt.busy, if_rt.dropped});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if ({if_rt.out, if_rt.busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_no_resume[%0d]: got out/busy=%b want 00",
                         k, {if_rt.out, if_rt.busy});
            end
        end
    endtask

    task automatic test_single();
        // len=3: out high after edges 0..2, busy low after edge 3+HOLDOFF.
        bit exp_out  [7] = '{1, 1, 1, 0, 0, 0, 0};
        bit exp_busy [7] = '{1, 1, 1, 1, 1, 0, 0};
        if_rt.len = 8'd3;
        if_rt.in  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            if_rt.in = 1'b0;
            n_cmp++;
            if ({if_rt.out, if_rt.busy, if_rt.dropped} !== {exp_out[k], exp_busy[k], 1'b0}) begin
                n_fail++;
                $display("FAIL single_len3[%0d]: got out/busy/dropped=%b want %b%b0",
                         k, {if_rt.out, if_rt.busy, if_rt.dropped}, exp_out[k], exp_busy[k]);
            end
        end
    endtask

    task automatic test_retrigger();
        // len=4, in at edges 0 and 2: out high after edges 0..5.
        if_rt.len = 8'd4;
        for (int k = 0; k < 9; k++) begin
            if_rt.in = (k == 0 || k == 2);
            step();
            n_cmp++;
            if ({if_rt.out, if_rt.dropped} !== {(k <= 5), 1'b0}) begin
                n_fail++;
                $display("FAIL retrigger[%0d]: got out/dropped=%b want %b0",
                         k, {if_rt.out, if_rt.dropped}, (k <= 5));
            end
        end
        idle_both(4);
    endtask

    task automatic test_no_retrigger();
        // len=4, in at edges 0 and 2: out high after edges 0..3, dropped after 2.
        if_nr.len = 8'd4;
        for (int k = 0; k < 8; k++) begin
            if_nr.in = (k == 0 || k == 2);
            step();
            n_cmp++;
            if ({if_nr.out, if_nr.dropped} !== {(k <= 3), (k == 2)}) begin
                n_fail++;
                $display("FAIL no_retrigger[%0d]: got out/dropped=%b want %b%b",
                         k, {if_nr.out, if_nr.dropped}, (k <= 3), (k == 2));
            end
        end
        idle_both(4);
    endtask

    task automatic test_holdoff();
        // RETRIGGER=0, HOLDOFF=2, len=1, in at edges 0..3.
        bit exp_out  [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        bit exp_busy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        bit exp_drop [8] = '{0, 1, 1, 0, 0, 0, 0, 0};
        if_nr.len = 8'd1;
        for (int k = 0; k < 8; k++) begin
            if_nr.in = (k <= 3);
            step();
            n_cmp++;
            if ({if_nr.out, if_nr.busy, if_nr.dropped} !== {exp_out[k], exp_busy[k], exp_drop[k]}) begin
                n_fail++;
                $display("FAIL holdoff[%0d]: got out/busy/dropped=%b want %b%b%b",
                         k, {if_nr.out, if_nr.busy, if_nr.dropped},
                         exp_out[k], exp_busy[k], exp_drop[k]);
            end
        end
        idle_both(2);
    endtask

    task automatic test_len_zero();
        if_rt.len = 8'd0;
        if_rt.in  = 1'b1;
        step();
        n_cmp++;
        if ({if_rt.out, if_rt.busy, if_rt.dropped} !== 3'b001) begin
            n_fail++;
            $display("FAIL len_zero_edge: got out/busy/dropped=%b want 001",
                     {if_rt.out, if_rt.busy, if_rt.dropped});
        end
        if_rt.in = 1'b0;
        step();
        n_cmp++;
        if ({if_rt.out, if_rt.busy, if_rt.dropped} !== 3'b000) begin
            n_fail++;
            $display("FAIL len_zero_after: got out/busy/dropped=%b want 000",
                     {if_rt.out, if_rt.busy, if_rt.dropped});
        end
    endtask

    task automatic test_len_max();
        // len=255; len is changed right after acceptance and must be ignored.
        int hi = 0;
        bit ended = 1'b0;
        if_rt.len = 8'd255;
        if_rt.in  = 1'b1;
        for (int k = 0; k < 300 && !ended; k++) begin
            step();
            if (k == 0) begin
                if_rt.in  = 1'b0;
                if_rt.len = 8'd2;
            end
            if (if_rt.out === 1'b1) hi++;
            else ended = 1'b1;
        end
        n_cmp++;
        if (!ended || hi != 255) begin
            n_fail++;
            $display("FAIL len_max: got %0d high cycles (ended=%0b) want 255", hi, ended);
        end
        idle_both(4);
        n_cmp++;
        if (if_rt.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len_max_idle: got busy=%b want 0", if_rt.busy);
        end
    endtask

    task automatic test_back_to_back();
        // RETRIGGER=1, in held for 5 edges with len=2: out high while in is
        // high, then 2 more cycles (edges 0..5 high, low after edge 6).
        if_rt.len = 8'd2;
        for (int k = 0; k < 9; k++) begin
            if_rt.in = (k <= 4);
            step();
            n_cmp++;
            if ({if_rt.out, if_rt.dropped} !== {(k <= 5), 1'b0}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got out/dropped=%b want %b0",
                         k, {if_rt.out, if_rt.dropped}, (k <= 5));
            end
        end
        idle_both(4);
    endtask

    initial begin
        if_rt.in  = 1'b0;
        if_rt.len = '0;
        if_nr.in  = 1'b0;
        if_nr.len = '0;

        test_reset();
        idle_both(2);
        test_single();
        idle_both(2);
        test_retrigger();
        test_no_retrigger();
        test_holdoff();
        test_len_zero();
        test_len_max();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
